demux_scan_ctrl: RTL and testbench

DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

---
 rtl/demux_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_demux_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_ctrl.sv
// ============================================================================
// demux_scan_ctrl
// ----------------------------------------------------------------------------
// Round-robin scan controller for a downstream 1:8 demultiplexer. While
// scanning, it holds each enabled channel for dwell+1 cycles and then moves
// on to the next enabled channel, wrapping around at the top. The serial
// input is gated onto the demux data line only while the selected channel
// is enabled.
//
// Parameters
//   DWELL_W     width of the dwell count
//
// Ports
//   clk         single clock, rising-edge active
//   rst         asynchronous, active-high reset
//   en          scan enable
//   mask[7:0]   per-channel enable, bit n = channel n participates
//   dwell       each channel is held for dwell+1 cycles (sampled every cycle)
//   din         serial data to be routed
//   I           gated data to the demux data input (din & busy & mask[S])
//   S[2:0]      registered channel select to the demux
//   ch_done     pulse on the last dwell cycle of a channel
//   frame_done  pulse on the cycle where the scan wraps back to a lower or
//               equal channel index
//   busy        high while scanning
// ============================================================================
module demux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               din,
    output logic               I,
    output logic [2:0]         S,
    output logic               ch_done,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         s_q, s_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [2:0]         next_ch;
    logic               mask_any;
    logic               cur_enabled;
    logic               scan_go;
    logic               dwell_end;
    logic               wraps;

    // Lowest enabled channel above c, searching upward with wrap-around.
    // The final probe (k=8) lands back on c itself, so a lone enabled
    // channel selects itself. With an empty mask c is returned unchanged.
    function automatic logic [2:0] find_next(input logic [2:0] c,
                                             input logic [7:0] m);
        logic [2:0] result;
        logic [2:0] idx;
        logic       found;
        result = c;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = c + 3'(k);
            if (!found && m[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign next_ch     = find_next(s_q, mask);
    assign mask_any    = |mask;
    assign cur_enabled = mask[s_q];

    // Scanning continues this cycle only if we are in SCAN and neither en
    // nor the mask is about to send us back to IDLE; the exit cycle must
    // not produce any pulse.
    assign scan_go     = (state_q == SCAN) && en && mask_any;

    // A dwell shortened below the running count still ends the channel at
    // the next compare rather than letting the count run away.
    assign dwell_end   = cnt_q >= dwell;

    // Moving to an index at or below the current one means the frame has
    // wrapped; this also covers single-channel operation.
    assign wraps       = next_ch <= s_q;

    // Next-state computation for the mode, channel select and dwell count.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en && mask_any) begin
                    state_d = SCAN;
                    s_d     = cur_enabled ? s_q : next_ch;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (!en || !mask_any) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!cur_enabled || dwell_end) begin
                    s_d     = next_ch;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset parks on channel 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decodes. busy comes straight from the state flop, so en has
    // no combinational path to it. A channel dropped from the mask mid-dwell
    // is skipped without ch_done but may still report a frame wrap.
    always_comb begin
        busy       = (state_q == SCAN);
        S          = s_q;
        ch_done    = scan_go && cur_enabled && dwell_end;
        frame_done = scan_go && (!cur_enabled || dwell_end) && wraps;
        I          = din && busy && cur_enabled;
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// ============================================================================
// tb_demux_scan_ctrl
// ----------------------------------------------------------------------------
// Directed bench for demux_scan_ctrl. Inputs change 2 time units after a
// rising edge; outputs are compared 2-3 units after the edge, well away from
// it. Each compare packs {busy, ch_done, frame_done, I, 0, S} into a byte.
// ============================================================================
module tb_demux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic       din;
    logic       I;
    logic [2:0] S;
    logic       ch_done;
    logic       frame_done;
    logic       busy;

    int total;
    int bad;

    demux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mask       (mask),
        .dwell      (dwell),
        .din        (din),
        .I          (I),
        .S          (S),
        .ch_done    (ch_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all scan inputs at once.
    task automatic applyStimulus(input logic e, input logic [7:0] m,
                                 input logic [3:0] d, input logic di);
        en    = e;
        mask  = m;
        dwell = d;
        din   = di;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pack(input logic b, input logic c,
                                        input logic f, input logic i,
                                        input logic [2:0] s);
        return {1'b0, b, c, f, i, 1'b0, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = pack(busy, ch_done, frame_done, I, S);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%02h expected=%02h (busy,ch,fr,I,0,S)",
                   tag, obs, expv);
        end
    endtask

    initial begin
        logic [2:0] s_exp;
        logic       ch_exp;
        logic [2:0] sparse_seq [7];
        total = 0;
        bad   = 0;
        sparse_seq = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7, 3'd1};

        // ---------------- reset ----------------
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        #12;
        checkOutput("reset_hold", pack(0, 0, 0, 0, 3'd0));
        rst = 1'b0;
        step();
        checkOutput("idle_after_reset", pack(0, 0, 0, 0, 3'd0));

        // ---------------- full round-robin, dwell=2 ----------------
        applyStimulus(1'b1, 8'hFF, 4'd2, 1'b1);
        #1;
        checkOutput("rr_idle_before_edge", pack(0, 0, 0, 0, 3'd0));
        for (int k = 0; k < 27; k++) begin
            step();
            s_exp  = 3'((k / 3) % 8);
            ch_exp = (k % 3) == 2;
            checkOutput($sformatf("rr_k%0d", k),
                        pack(1, ch_exp, ch_exp && (s_exp == 3'd7), 1, s_exp));
        end
        // en drops on a would-be ch_done cycle: no pulse, still busy
        en = 1'b0;
        #1;
        checkOutput("rr_en_drop_no_pulse", pack(1, 0, 0, 1, 3'd0));
        step();
        checkOutput("rr_idle_hold", pack(0, 0, 0, 0, 3'd0));

        // ---------------- sparse mask, dwell=0 ----------------
        applyStimulus(1'b1, 8'b1001_0010, 4'd0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step();
            checkOutput($sformatf("sparse_k%0d", k),
                        pack(1, 1, sparse_seq[k] == 3'd7, 1, sparse_seq[k]));
        end
        en = 1'b0;
        step();
        checkOutput("sparse_idle", pack(0, 0, 0, 0, 3'd1));

        // ---------------- single channel with din gating ----------------
        applyStimulus(1'b1, 8'h08, 4'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            din = (k % 3) == 0;
            #1;
            checkOutput($sformatf("single_k%0d", k),
                        pack(1, k[0], k[0], (k % 3) == 0, 3'd3));
        end
        en = 1'b0;
        step();
        checkOutput("single_idle", pack(0, 0, 0, 0, 3'd3));

        // ---------------- mid-dwell mask drop ----------------
        applyStimulus(1'b1, 8'h04, 4'd5, 1'b1);
        step();
        checkOutput("drop_enter_s2", pack(1, 0, 0, 1, 3'd2));
        mask = 8'hFF;
        step();
        checkOutput("drop_s2_cnt1", pack(1, 0, 0, 1, 3'd2));
        mask = 8'hF3;
        #1;
        checkOutput("drop_masked_now", pack(1, 0, 0, 0, 3'd2));
        step();
        checkOutput("drop_skip_to_s4", pack(1, 0, 0, 1, 3'd4));
        dwell = 4'd0;
        #1;
        checkOutput("drop_dwell_change", pack(1, 1, 0, 1, 3'd4));
        step();
        checkOutput("drop_to_s5", pack(1, 1, 0, 1, 3'd5));

        // ---------------- enable toggling at S=5 ----------------
        dwell = 4'd3;
        en    = 1'b0;
        #1;
        checkOutput("en_fall_busy_reg", pack(1, 0, 0, 1, 3'd5));
        step();
        checkOutput("en_idle_s5", pack(0, 0, 0, 0, 3'd5));
        step();
        checkOutput("en_idle_s5_hold", pack(0, 0, 0, 0, 3'd5));
        en = 1'b1;
        #1;
        checkOutput("en_rise_no_comb", pack(0, 0, 0, 0, 3'd5));
        step();
        checkOutput("en_resume_cnt0", pack(1, 0, 0, 1, 3'd5));
        step();
        checkOutput("en_resume_cnt1", pack(1, 0, 0, 1, 3'd5));
        step();
        checkOutput("en_resume_cnt2", pack(1, 0, 0, 1, 3'd5));
        step();
        checkOutput("en_resume_cnt3", pack(1, 1, 0, 1, 3'd5));
        step();
        checkOutput("en_next_s6", pack(1, 0, 0, 1, 3'd6));

        // ---------------- async reset mid-scan ----------------
        rst = 1'b1;
        #1;
        checkOutput("async_rst_zero", pack(0, 0, 0, 0, 3'd0));
        mask = 8'h01;
        rst  = 1'b0;
        #1;
        checkOutput("async_rst_release", pack(0, 0, 0, 0, 3'd0));
        step();
        checkOutput("post_rst_scan_s0", pack(1, 0, 0, 1, 3'd0));
        din = 1'b0;
        #1;
        checkOutput("post_rst_din_low", pack(1, 0, 0, 0, 3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
